pattern_sequencer: RTL and testbench

- Sequential successor to the combinational nucleotide pattern decoder. Holds a small pattern program in an internal register file.
- On `start`, walks the program one element at a time against a valid/ready nucleotide stream. Supports literals, wildcard, 2/3-way alternation, exact-count repeat and up-to repeat.
- Reports a single anchored match/no-match/error verdict plus the number of nucleotides consumed.
- Sits between the nucleotide source and the lab top-level control.

---
 rtl/pattern_sequencer_if.sv | 45 ++++
 rtl/pattern_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if: pattern-load, run-control and nucleotide-stream signals of the
// pattern sequencer. The controller side uses master and the sequencer uses slave.
// When PATSEQ_UNANCHORED_EN is defined, the interface also carries match_pos.
interface pattern_sequencer_if #(
    parameter int unsigned NW    = 2,
    parameter int unsigned PW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          pat_we;
    logic [AW-1:0] pat_addr;
    logic [PW-1:0] pat_data;
    logic          start;
    logic [NW-1:0] nuc;
    logic          nuc_valid;
    logic          nuc_ready;
    logic          busy;
    logic          done;
    logic          matched;
    logic          error;
    logic [LW-1:0] match_len;
`ifdef PATSEQ_UNANCHORED_EN
    logic [LW-1:0] match_pos;
`endif

    modport master (
        output pat_we, pat_addr, pat_data, start, nuc, nuc_valid,
        input  nuc_ready, busy, done, matched, error,
`ifdef PATSEQ_UNANCHORED_EN
        input  match_pos,
`endif
        input  match_len
    );

    modport slave (
        input  pat_we, pat_addr, pat_data, start, nuc, nuc_valid,
        output nuc_ready, busy, done, matched, error,
`ifdef PATSEQ_UNANCHORED_EN
        output match_pos,
`endif
        output match_len
    );
endinterface

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: executes a small pattern program held in an internal register file
// against a valid/ready nucleotide stream. It reports a match, no-match or error verdict
// and the number of nucleotides consumed.
// Optional feature macro: PATSEQ_UNANCHORED_EN. When it is defined, a mismatch restarts the
// program at pc=0 instead of failing, and match_pos reports where the last attempt began.
module pattern_sequencer #(
    parameter int unsigned NW    = 2,
    parameter int unsigned PW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = 8
) (
    input  logic               clock,
    input  logic               reset_L,
    pattern_sequencer_if.slave bus
);
    localparam int unsigned   AW     = $clog2(DEPTH);
    // pc carries one extra bit so that running off the end of the program can be detected
    localparam logic [AW:0]   PcEnd  = (AW+1)'(DEPTH);
    localparam logic [LW-1:0] LenMax = '1;

    typedef enum logic [1:0] {StIdle, StExec, StRepeat, StDone} state_e;

    state_e        r_state, w_state_nxt;
    logic [AW:0]   r_pc, w_pc_nxt;
    logic [4:0]    r_cnt, w_cnt_nxt;
    logic          r_upto, w_upto_nxt;
    logic [LW-1:0] r_len, w_len_nxt;
    logic          r_done, w_done_nxt;
    logic          r_matched, w_matched_nxt;
    logic          r_error, w_error_nxt;
    logic [PW-1:0] r_mem [DEPTH];
`ifdef PATSEQ_UNANCHORED_EN
    logic [LW-1:0] r_total, w_total_nxt;
    logic [LW-1:0] r_pos, w_pos_nxt;
`endif

    logic          w_busy, w_ready, w_hit, w_mismatch, w_err;
    logic [AW:0]   w_pc1, w_pc2, w_pc3;
    logic [PW-1:0] w_op0, w_op1, w_op2, w_op3;
    logic          w_in0, w_in1, w_in2, w_in3;
    logic          w_alt3, w_alt_ok, w_alt_hit;
    logic          w_cls_upto;

    function automatic logic lit_ok(input logic [3:0] k);
        return (32'(k) >> NW) == 32'd0;
    endfunction

    function automatic logic is_lit(input logic [7:0] op);
        return (op[7:4] == 4'h1) && lit_ok(op[3:0]);
    endfunction

    function automatic logic is_elem(input logic [7:0] op);
        return (op == 8'h20) || is_lit(op);
    endfunction

    // Only meaningful when op is a legal LIT or ANY
    function automatic logic elem_hit(input logic [7:0] op, input logic [NW-1:0] n);
        return (op == 8'h20) || (n == op[NW-1:0]);
    endfunction

    function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
        return (v == LenMax) ? v : v + LW'(1);
    endfunction

    assign w_pc1  = r_pc + (AW+1)'(1);
    assign w_pc2  = r_pc + (AW+1)'(2);
    assign w_pc3  = r_pc + (AW+1)'(3);
    assign w_in0  = (r_pc < PcEnd);
    assign w_in1  = (w_pc1 < PcEnd);
    assign w_in2  = (w_pc2 < PcEnd);
    assign w_in3  = (w_pc3 < PcEnd);
    assign w_op0  = r_mem[r_pc[AW-1:0]];
    assign w_op1  = r_mem[w_pc1[AW-1:0]];
    assign w_op2  = r_mem[w_pc2[AW-1:0]];
    assign w_op3  = r_mem[w_pc3[AW-1:0]];

    assign w_cls_upto = (w_op0[7:4] == 4'h3);
    assign w_alt3     = (w_op0 == 8'h22);
    assign w_alt_ok   = w_in1 && w_in2 && is_lit(w_op1) && is_lit(w_op2) &&
                        (!w_alt3 || (w_in3 && is_lit(w_op3)));
    assign w_alt_hit  = elem_hit(w_op1, bus.nuc) || elem_hit(w_op2, bus.nuc) ||
                        (w_alt3 && elem_hit(w_op3, bus.nuc));

    assign w_busy        = (r_state == StExec) || (r_state == StRepeat);
    assign bus.busy      = w_busy;
    assign bus.nuc_ready = w_ready;
    assign bus.done      = r_done;
    assign bus.matched   = r_matched;
    assign bus.error     = r_error;
    assign bus.match_len = r_len;
`ifdef PATSEQ_UNANCHORED_EN
    assign bus.match_pos = r_pos;
`endif

    // Pattern memory: written only while idle, never cleared by reset
    always_ff @(posedge clock) begin
        if (bus.pat_we && !w_busy) begin
            r_mem[bus.pat_addr] <= bus.pat_data;
        end
    end

    // Control state and verdict registers
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_state   <= StIdle;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_upto    <= 1'b0;
            r_len     <= '0;
            r_done    <= 1'b0;
            r_matched <= 1'b0;
            r_error   <= 1'b0;
`ifdef PATSEQ_UNANCHORED_EN
            r_total   <= '0;
            r_pos     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_upto    <= w_upto_nxt;
            r_len     <= w_len_nxt;
            r_done    <= w_done_nxt;
            r_matched <= w_matched_nxt;
            r_error   <= w_error_nxt;
`ifdef PATSEQ_UNANCHORED_EN
            r_total   <= w_total_nxt;
            r_pos     <= w_pos_nxt;
`endif
        end
    end

    // Next-state decode: one program element per cycle, at most one nucleotide consumed
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_upto_nxt    = r_upto;
        w_len_nxt     = r_len;
        w_done_nxt    = r_done;
        w_matched_nxt = r_matched;
        w_error_nxt   = r_error;
`ifdef PATSEQ_UNANCHORED_EN
        w_total_nxt   = r_total;
        w_pos_nxt     = r_pos;
`endif
        w_ready    = 1'b0;
        w_hit      = 1'b0;
        w_mismatch = 1'b0;
        w_err      = 1'b0;

        unique case (r_state)
            StIdle, StDone: begin
                if (bus.start) begin
                    w_state_nxt   = StExec;
                    w_pc_nxt      = '0;
                    w_cnt_nxt     = '0;
                    w_len_nxt     = '0;
                    w_done_nxt    = 1'b0;
                    w_matched_nxt = 1'b0;
                    w_error_nxt   = 1'b0;
`ifdef PATSEQ_UNANCHORED_EN
                    w_total_nxt   = '0;
                    w_pos_nxt     = '0;
`endif
                end
            end
            StExec: begin
                if (!w_in0) begin
                    w_err = 1'b1;
                end else if (w_op0 == 8'h00) begin
                    w_state_nxt   = StDone;
                    w_done_nxt    = 1'b1;
                    w_matched_nxt = 1'b1;
                end else if ((w_op0[7:4] == 4'h0) || w_cls_upto) begin
                    // Repeat prefix: latch the count and hand the next element to StRepeat
                    w_upto_nxt  = w_cls_upto;
                    w_cnt_nxt   = w_cls_upto ? (5'd16 - {1'b0, w_op0[3:0]}) : {1'b0, w_op0[3:0]};
                    w_pc_nxt    = w_pc1;
                    w_state_nxt = StRepeat;
                end else if (is_elem(w_op0)) begin
                    if (bus.nuc_valid) begin
                        w_ready = 1'b1;
                        if (elem_hit(w_op0, bus.nuc)) begin
                            w_hit    = 1'b1;
                            w_pc_nxt = w_pc1;
                        end else begin
                            w_mismatch = 1'b1;
                        end
                    end
                end else if ((w_op0 == 8'h21) || w_alt3) begin
                    // Bad or out-of-range operands are a program error, reported without waiting
                    if (!w_alt_ok) begin
                        w_err = 1'b1;
                    end else if (bus.nuc_valid) begin
                        w_ready = 1'b1;
                        if (w_alt_hit) begin
                            w_hit    = 1'b1;
                            w_pc_nxt = w_alt3 ? (w_pc3 + (AW+1)'(1)) : w_pc3;
                        end else begin
                            w_mismatch = 1'b1;
                        end
                    end
                end else begin
                    w_err = 1'b1;
                end
            end
            StRepeat: begin
                if (!w_in0 || !is_elem(w_op0)) begin
                    w_err = 1'b1;
                end else if (bus.nuc_valid) begin
                    if (elem_hit(w_op0, bus.nuc)) begin
                        w_ready = 1'b1;
                        w_hit   = 1'b1;
                        if (r_cnt == 5'd1) begin
                            w_pc_nxt    = w_pc1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = StExec;
                        end else begin
                            w_cnt_nxt = r_cnt - 5'd1;
                        end
                    end else if (r_upto) begin
                        // Greedy repeat stops here; the same nucleotide is retried by the next element
                        w_pc_nxt    = w_pc1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StExec;
                    end else begin
                        w_ready    = 1'b1;
                        w_mismatch = 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_hit) begin
            w_len_nxt = sat_inc(r_len);
        end
`ifdef PATSEQ_UNANCHORED_EN
        if (w_ready) begin
            w_total_nxt = sat_inc(r_total);
        end
`endif
        if (w_mismatch) begin
`ifdef PATSEQ_UNANCHORED_EN
            // Drop the offending nucleotide and retry the whole program after it
            w_pc_nxt    = '0;
            w_cnt_nxt   = '0;
            w_len_nxt   = '0;
            w_pos_nxt   = sat_inc(r_total);
            w_state_nxt = StExec;
`else
            w_state_nxt   = StDone;
            w_done_nxt    = 1'b1;
            w_matched_nxt = 1'b0;
`endif
        end
        if (w_err) begin
            w_state_nxt   = StDone;
            w_done_nxt    = 1'b1;
            w_matched_nxt = 1'b0;
            w_error_nxt   = 1'b1;
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed scenarios plus randomized programs and streams, checked
// against an element-level reference interpreter of the pattern language.
module tb_pattern_sequencer;
    localparam int unsigned NW    = 2;
    localparam int unsigned PW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 8;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic clock = 1'b0;
    logic reset_L;
    always #5 clock = ~clock;

    pattern_sequencer_if #(.NW(NW), .PW(PW), .DEPTH(DEPTH), .LW(LW)) bus_if ();

    pattern_sequencer #(.NW(NW), .PW(PW), .DEPTH(DEPTH), .LW(LW)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prog [DEPTH];
    int         strm [64];

    // Results of the last do_run
    bit  run_done;
    int  run_used, run_viol, run_busy_drop;
    bit  o_m, o_e;
    int  o_len, o_pos;

    function automatic bit lit_legal(input logic [7:0] b);
        return (b[7:4] == 4'h1) && (int'(b[3:0]) < (1 << NW));
    endfunction

    function automatic bit elem_ok(input logic [7:0] b);
        return (b == 8'h20) || lit_legal(b);
    endfunction

    function automatic bit hits(input logic [7:0] b, input int x);
        return (b == 8'h20) || (int'(b[3:0]) == x);
    endfunction

    // Reference interpreter over the program and the first n stream entries
    function automatic void model(input int n, output bit m, output bit e, output int len,
                                  output int used, output int pos, output bit starved);
        int pc, idx, steps, cnt, got, k;
        bit upto, miss, bad, hit;
        logic [7:0] op;
        pc = 0; idx = 0; steps = 0;
        m = 0; e = 0; len = 0; pos = 0; starved = 0;
        forever begin
            miss = 0;
            steps++;
            if (steps > 2000) begin starved = 1; break; end
            if (pc >= DEPTH) begin e = 1; break; end
            op = prog[pc];
            if (op == 8'h00) begin
                m = 1; break;
            end else if (op[7:4] == 4'h0 || op[7:4] == 4'h3) begin
                upto = (op[7:4] == 4'h3);
                cnt  = upto ? 16 - int'(op[3:0]) : int'(op[3:0]);
                got  = 0;
                pc++;
                if (pc >= DEPTH || !elem_ok(prog[pc])) begin e = 1; break; end
                while (got < cnt && !miss && !starved) begin
                    if (idx >= n) starved = 1;
                    else if (hits(prog[pc], strm[idx])) begin idx++; len++; got++; end
                    else if (upto) break;
                    else begin idx++; miss = 1; end
                end
                if (starved) break;
                if (!miss) pc++;
            end else if (elem_ok(op)) begin
                if (idx >= n) begin starved = 1; break; end
                if (hits(op, strm[idx])) begin idx++; len++; pc++; end
                else begin idx++; miss = 1; end
            end else if (op == 8'h21 || op == 8'h22) begin
                k = (op == 8'h21) ? 2 : 3;
                bad = 0; hit = 0;
                for (int j = 1; j <= k; j++)
                    if (pc + j >= DEPTH || !lit_legal(prog[pc+j])) bad = 1;
                if (bad) begin e = 1; break; end
                if (idx >= n) begin starved = 1; break; end
                for (int j = 1; j <= k; j++)
                    if (int'(prog[pc+j][3:0]) == strm[idx]) hit = 1;
                idx++;
                if (hit) begin len++; pc += k + 1; end
                else miss = 1;
            end else begin
                e = 1; break;
            end
            if (miss) begin
`ifdef PATSEQ_UNANCHORED_EN
                pos = idx; len = 0; pc = 0;
`else
                break;
`endif
            end
        end
        used = idx;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset_L = 1'b0;
        bus_if.nuc_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            bus_if.pat_we   = 1'b1;
            bus_if.pat_addr = AW'(i);
            bus_if.pat_data = prog[i];
        end
        @(negedge clock);
        bus_if.pat_we = 1'b0;
    endtask

    // Start a run and feed strm[0..n-1]; optional random gaps, a 5-cycle stall at
    // stream index stall_at, and an entry-0 write issued together with start
    task automatic do_run(input int n, input bit gaps, input int stall_at,
                          input bit we, input logic [7:0] wdata);
        int idx, cyc, stalls;
        logic v;
        idx = 0; cyc = 0; stalls = 0;
        run_done = 0; run_viol = 0; run_busy_drop = 0;
        @(negedge clock);
        bus_if.start     = 1'b1;
        bus_if.nuc_valid = 1'b0;
        bus_if.pat_we    = we;
        bus_if.pat_addr  = '0;
        bus_if.pat_data  = wdata;
        @(negedge clock);
        bus_if.start  = 1'b0;
        bus_if.pat_we = 1'b0;
        while (!run_done && cyc < 400) begin
            v = (idx < n) && (!gaps || $urandom_range(0, 3) != 0);
            if (idx == stall_at && stalls < 5) begin
                v = 1'b0;
                stalls++;
            end
            bus_if.nuc_valid = v;
            bus_if.nuc       = v ? NW'(strm[idx]) : NW'($urandom);
            #1;
            if (bus_if.done === 1'b1) begin
                run_done = 1;
            end else begin
                if (bus_if.nuc_ready !== 1'b0 && !v) run_viol++;
                if (stalls > 0 && stalls <= 5 && !v && bus_if.busy !== 1'b1) run_busy_drop++;
                if (v && bus_if.nuc_ready === 1'b1) idx++;
                @(negedge clock);
                cyc++;
            end
        end
        bus_if.nuc_valid = 1'b0;
        run_used = idx;
        o_m   = bus_if.matched;
        o_e   = bus_if.error;
        o_len = int'(bus_if.match_len);
`ifdef PATSEQ_UNANCHORED_EN
        o_pos = int'(bus_if.match_pos);
`else
        o_pos = 0;
`endif
    endtask

    task automatic test_reset();
        apply_reset();
        bus_if.nuc_valid = 1'b1;
        #1;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus_if.busy); else n_pass++;
        n_checks++; if (bus_if.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus_if.done); else n_pass++;
        n_checks++; if (bus_if.matched !== 1'b0 || bus_if.error !== 1'b0)
            $display("FAIL reset_flags got=%b%b want=00", bus_if.matched, bus_if.error); else n_pass++;
        n_checks++; if (bus_if.match_len !== '0) $display("FAIL reset_len got=%0d want=0", bus_if.match_len); else n_pass++;
        n_checks++; if (bus_if.nuc_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", bus_if.nuc_ready); else n_pass++;
`ifdef PATSEQ_UNANCHORED_EN
        n_checks++; if (bus_if.match_pos !== '0) $display("FAIL reset_pos got=%0d want=0", bus_if.match_pos); else n_pass++;
`endif
        bus_if.nuc_valid = 1'b0;
    endtask

    task automatic test_literal();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h13; prog[1] = 8'h11;
        strm[0] = 3; strm[1] = 1;
        load_prog();
        do_run(2, 0, -1, 0, 8'h00);
        n_checks++; if (!run_done) $display("FAIL lit_done got=timeout want=done"); else n_pass++;
        n_checks++; if (o_m !== 1'b1 || o_e !== 1'b0) $display("FAIL lit_verdict got=m%b e%b want=m1 e0", o_m, o_e); else n_pass++;
        n_checks++; if (o_len != 2 || run_used != 2) $display("FAIL lit_len got=%0d/%0d want=2/2", o_len, run_used); else n_pass++;
        repeat (3) @(negedge clock);
        #1;
        n_checks++; if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0)
            $display("FAIL lit_done_hold got=d%b b%b want=d1 b0", bus_if.done, bus_if.busy); else n_pass++;
    endtask

`ifndef PATSEQ_UNANCHORED_EN
    task automatic test_exact_fail();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h03; prog[1] = 8'h12;
        strm[0] = 2; strm[1] = 2; strm[2] = 1;
        load_prog();
        do_run(3, 0, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_m !== 1'b0 || o_e !== 1'b0)
            $display("FAIL exact_verdict got=d%0b m%b e%b want=d1 m0 e0", run_done, o_m, o_e); else n_pass++;
        n_checks++; if (o_len != 2 || run_used != 3) $display("FAIL exact_len got=%0d/%0d want=2/3", o_len, run_used); else n_pass++;
    endtask
`endif

    task automatic test_upto();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h3D; prog[1] = 8'h10; prog[2] = 8'h11;
        strm[0] = 0; strm[1] = 1;
        load_prog();
        do_run(2, 0, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_m !== 1'b1) $display("FAIL upto_matched got=d%0b m%b want=d1 m1", run_done, o_m); else n_pass++;
        n_checks++; if (o_len != 2 || run_used != 2) $display("FAIL upto_len got=%0d/%0d want=2/2", o_len, run_used); else n_pass++;
    endtask

    task automatic test_alt();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h22; prog[1] = 8'h10; prog[2] = 8'h12; prog[3] = 8'h13;
        strm[0] = 2;
        load_prog();
        do_run(1, 0, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_m !== 1'b1 || o_len != 1)
            $display("FAIL alt_match got=d%0b m%b len%0d want=d1 m1 len1", run_done, o_m, o_len); else n_pass++;
        prog[2] = 8'h20;
        load_prog();
        do_run(1, 0, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_e !== 1'b1 || o_m !== 1'b0)
            $display("FAIL alt_err got=d%0b e%b m%b want=d1 e1 m0", run_done, o_e, o_m); else n_pass++;
        n_checks++; if (run_used != 0) $display("FAIL alt_err_consume got=%0d want=0", run_used); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin prog[i] = 8'h20; strm[i] = i % 4; end
        load_prog();
        do_run(DEPTH, 1, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_e !== 1'b1 || run_used != DEPTH)
            $display("FAIL ovf_noend got=d%0b e%b used%0d want=d1 e1 used%0d", run_done, o_e, run_used, DEPTH); else n_pass++;
        prog[DEPTH-2] = 8'h21; prog[DEPTH-1] = 8'h10;
        load_prog();
        do_run(DEPTH, 0, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_e !== 1'b1 || run_used != DEPTH - 2)
            $display("FAIL ovf_alt got=d%0b e%b used%0d want=d1 e1 used%0d", run_done, o_e, run_used, DEPTH - 2); else n_pass++;
        prog[0] = 8'h14;
        load_prog();
        do_run(DEPTH, 0, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_e !== 1'b1 || run_used != 0)
            $display("FAIL illegal_lit got=d%0b e%b used%0d want=d1 e1 used0", run_done, o_e, run_used); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h13; prog[1] = 8'h11;
        strm[0] = 3; strm[1] = 1;
        load_prog();
        do_run(2, 0, 1, 0, 8'h00);
        n_checks++; if (run_viol != 0) $display("FAIL stall_ready got=%0d want=0", run_viol); else n_pass++;
        n_checks++; if (run_busy_drop != 0) $display("FAIL stall_busy got=%0d want=0", run_busy_drop); else n_pass++;
        n_checks++; if (!run_done || o_m !== 1'b1 || o_len != 2)
            $display("FAIL stall_verdict got=d%0b m%b len%0d want=d1 m1 len2", run_done, o_m, o_len); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h10; prog[1] = 8'h11; prog[2] = 8'h12;
        load_prog();
        @(negedge clock);
        bus_if.start = 1'b1;
        @(negedge clock);
        bus_if.start     = 1'b0;
        bus_if.nuc_valid = 1'b1;
        bus_if.nuc       = 2'd0;
        @(negedge clock);
        bus_if.nuc_valid = 1'b0;
        reset_L = 1'b0;
        @(negedge clock);
        #1;
        n_checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
            $display("FAIL midreset got=b%b d%b want=b0 d0", bus_if.busy, bus_if.done); else n_pass++;
        n_checks++; if (bus_if.match_len !== '0) $display("FAIL midreset_len got=%0d want=0", bus_if.match_len); else n_pass++;
        reset_L = 1'b1;
        strm[0] = 0; strm[1] = 1; strm[2] = 2;
        do_run(3, 1, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_m !== 1'b1 || o_len != 3)
            $display("FAIL rerun got=d%0b m%b len%0d want=d1 m1 len3", run_done, o_m, o_len); else n_pass++;
    endtask

    task automatic test_simul_write();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h13;
        load_prog();
        apply_reset();
        strm[0] = 1;
        do_run(1, 0, -1, 1, 8'h11);
        n_checks++; if (!run_done || o_m !== 1'b1 || o_len != 1)
            $display("FAIL simul_write got=d%0b m%b len%0d want=d1 m1 len1", run_done, o_m, o_len); else n_pass++;
    endtask

`ifdef PATSEQ_UNANCHORED_EN
    task automatic test_unanchored();
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
        prog[0] = 8'h11; prog[1] = 8'h12;
        strm[0] = 0; strm[1] = 1; strm[2] = 2;
        load_prog();
        do_run(3, 0, -1, 0, 8'h00);
        n_checks++; if (!run_done || o_m !== 1'b1) $display("FAIL unanch_matched got=d%0b m%b want=d1 m1", run_done, o_m); else n_pass++;
        n_checks++; if (o_pos != 1 || o_len != 2) $display("FAIL unanch_pos got=%0d/%0d want=1/2", o_pos, o_len); else n_pass++;
    endtask
`endif

    function automatic logic [7:0] rand_lit();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return {4'h1, 4'($urandom_range(0, 15))};
        if (r <= 2) return {4'h1, 4'($urandom_range(0, 3))};
        return {4'h1, 4'($urandom_range(0, 1))};
    endfunction

    function automatic logic [7:0] rand_elem();
        return ($urandom_range(0, 4) == 0) ? 8'h20 : rand_lit();
    endfunction

    task automatic gen_case();
        int pc, kind, nel;
        pc  = 0;
        nel = $urandom_range(1, 4);
        for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
        for (int el = 0; el < nel && pc < 12; el++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 1) begin
                prog[pc] = rand_elem();
                pc += 1;
            end else if (kind <= 3) begin
                prog[pc] = (kind == 2) ? 8'h21 : 8'h22;
                for (int j = 1; j <= kind; j++) prog[pc+j] = rand_lit();
                pc += kind + 1;
            end else begin
                prog[pc] = (kind == 4) ? {4'h0, 4'($urandom_range(1, 3))}
                                       : {4'h3, 4'($urandom_range(13, 15))};
                prog[pc+1] = rand_elem();
                pc += 2;
            end
        end
        if ($urandom_range(0, 7) != 0) prog[pc] = 8'h00;
        for (int i = 0; i < 24; i++)
            strm[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1);
    endtask

    task automatic test_random();
        bit m, e, st;
        int len, used, pos, tries;
        for (int it = 0; it < 60; it++) begin
            tries = 0;
            do begin
                gen_case();
                model(24, m, e, len, used, pos, st);
                tries++;
            end while (st && tries < 50);
            if (st) continue;
            load_prog();
            do_run(24, 1, -1, 0, 8'h00);
            n_checks++; if (!run_done) $display("FAIL rand%0d_done got=timeout want=done", it); else n_pass++;
            n_checks++; if (o_m !== m || o_e !== e)
                $display("FAIL rand%0d_verdict got=m%b e%b want=m%b e%b", it, o_m, o_e, m, e); else n_pass++;
            n_checks++; if (o_len != len || run_used != used)
                $display("FAIL rand%0d_len got=%0d/%0d want=%0d/%0d", it, o_len, run_used, len, used); else n_pass++;
            n_checks++; if (run_viol != 0) $display("FAIL rand%0d_ready got=%0d want=0", it, run_viol); else n_pass++;
`ifdef PATSEQ_UNANCHORED_EN
            n_checks++; if (o_pos != pos) $display("FAIL rand%0d_pos got=%0d want=%0d", it, o_pos, pos); else n_pass++;
`endif
        end
    endtask

    initial begin
        reset_L          = 1'b0;
        bus_if.pat_we    = 1'b0;
        bus_if.pat_addr  = '0;
        bus_if.pat_data  = '0;
        bus_if.start     = 1'b0;
        bus_if.nuc       = '0;
        bus_if.nuc_valid = 1'b0;
        test_reset();
        test_literal();
`ifndef PATSEQ_UNANCHORED_EN
        test_exact_fail();
`endif
        test_upto();
        test_alt();
        test_overflow();
        test_stall();
        test_reset_midrun();
        test_simul_write();
`ifdef PATSEQ_UNANCHORED_EN
        test_unanchored();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
